day3_bank_loader: RTL

DAY3_BANK_LOADER -- requirements
Module: day3_bank_loader

---
 rtl/day3_bank_loader_pkg.sv | 27 ++
 rtl/day3_bank_loader_if.sv | 39 +++
 rtl/day3_char_decode.sv | 27 ++
 rtl/day3_bank_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/day3_bank_loader_pkg.sv
// Shared constants and types for the bank loader: ASCII codes, digit width,
// and the loader and character-class enums.
package day3_pkg;

  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiNine = 8'h39;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiCr   = 8'h0D;

  localparam int unsigned DigitW = 4;

  typedef enum logic [2:0] {
    StLoad,
    StClear,
    StStream,
    StDone,
    StFinished
  } loader_state_e;

  typedef enum logic [1:0] {
    ChDigit,
    ChNewline,
    ChReturn,
    ChIllegal
  } char_class_e;

endpackage

// File: rtl/day3_bank_loader_if.sv
// Byte-stream input and column-beat output bundle between the loader and its neighbours.
// The loader sits on the slave side; the byte source and lane array on the master side.
interface day3_bank_loader_if #(
  parameter int unsigned NUM_UNITS = 200
);
  import day3_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              out_clear;
  logic              out_en;
  logic [DigitW-1:0] out_battery [NUM_UNITS];
  logic              batch_done;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_clear,
    input  out_en,
    input  out_battery,
    input  batch_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_clear,
    output out_en,
    output out_battery,
    output batch_done
  );

endinterface

// File: rtl/day3_char_decode.sv
// Classifies an ASCII byte as digit, newline, carriage return or illegal and
// extracts the 4-bit digit value (meaningful only for the digit class).
module day3_char_decode
  import day3_pkg::*;
(
  input  logic [7:0]        data,
  output char_class_e       char_class,
  output logic [DigitW-1:0] digit
);

  logic [7:0] offset;

  always_comb begin
    offset = data - AsciiZero;
    digit  = offset[DigitW-1:0];
    if ((data >= AsciiZero) && (data <= AsciiNine)) begin
      char_class = ChDigit;
    end else if (data == AsciiLf) begin
      char_class = ChNewline;
    end else if (data == AsciiCr) begin
      char_class = ChReturn;
    end else begin
      char_class = ChIllegal;
    end
  end

endmodule

// File: rtl/day3_bank_loader.sv
// Captures NUM_UNITS lines of LINE_LEN ASCII digits, then streams them to the
// downstream lanes one column per beat, followed by a zero flush beat.
module day3_bank_loader
  import day3_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 200,
  parameter int unsigned LINE_LEN  = 100
) (
  input  logic                               clock,
  input  logic                               reset,
  day3_bank_loader_if.slave                  bus,
  output logic [$clog2(NUM_UNITS + 1)-1:0]   lanes_loaded,
  output logic                               err
);

  localparam int unsigned LanesW   = $clog2(NUM_UNITS + 1);
  localparam int unsigned ColW     = $clog2(LINE_LEN + 1);
  localparam int unsigned LaneIdxW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned ColIdxW  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  localparam logic [LanesW-1:0] NumUnitsC = LanesW'(NUM_UNITS);
  localparam logic [ColW-1:0]   LineLenC  = ColW'(LINE_LEN);

  loader_state_e     state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [ColW-1:0]   beat_q, beat_d;
  logic [LanesW-1:0] lanes_q, lanes_d;
  logic              err_q, err_d;
  logic              last_seen_q, last_seen_d;

  // Column-major store: one packed word of all lane digits per column.
  logic [NUM_UNITS-1:0][DigitW-1:0] mem_q [LINE_LEN];
  logic [NUM_UNITS-1:0][DigitW-1:0] col_word;

  char_class_e       in_class;
  logic [DigitW-1:0] in_digit;
  logic              wr_en;
  logic              line_end;
  logic [ColW-1:0]   col_fill;
  logic              beat_live;

  day3_char_decode u_char_decode (
    .data       (bus.in_data),
    .char_class (in_class),
    .digit      (in_digit)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      beat_q      <= '0;
      lanes_q     <= '0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      beat_q      <= beat_d;
      lanes_q     <= lanes_d;
      err_q       <= err_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Storage is never cleared; lanes beyond lanes_q are masked on readout.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[col_q[ColIdxW-1:0]][lanes_q[LaneIdxW-1:0]] <= in_digit;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    beat_d      = beat_q;
    lanes_d     = lanes_q;
    err_d       = err_q;
    last_seen_d = last_seen_q;
    wr_en       = 1'b0;
    line_end    = 1'b0;
    col_fill    = col_q;

    case (state_q)
      StLoad: begin
        if (bus.in_valid) begin
          if (in_class == ChDigit) begin
            if (col_q < LineLenC) begin
              wr_en    = 1'b1;
              col_fill = col_q + ColW'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (in_class == ChIllegal) begin
            err_d = 1'b1;
          end

          // in_last closes any partial line as if a newline followed.
          line_end = (in_class == ChNewline) || bus.in_last;
          col_d    = col_fill;
          if (line_end && (col_fill != '0)) begin
            lanes_d = lanes_q + LanesW'(1);
            col_d   = '0;
            if (col_fill != LineLenC) begin
              err_d = 1'b1;
            end
          end

          if (bus.in_last) begin
            last_seen_d = 1'b1;
            state_d     = (lanes_d == '0) ? StFinished : StClear;
          end else if (lanes_d == NumUnitsC) begin
            state_d = StClear;
          end
        end
      end
      StClear: begin
        beat_d  = '0;
        state_d = StStream;
      end
      StStream: begin
        if (beat_q == LineLenC) begin
          state_d = StDone;
        end else begin
          beat_d = beat_q + ColW'(1);
        end
      end
      StDone: begin
        if (last_seen_q) begin
          state_d = StFinished;
        end else begin
          state_d = StLoad;
          lanes_d = '0;
          col_d   = '0;
        end
      end
      StFinished: begin
        state_d = StFinished;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    bus.in_ready   = (state_q == StLoad);
    bus.out_clear  = (state_q == StClear);
    bus.out_en     = (state_q == StStream);
    bus.batch_done = (state_q == StDone);
  end

  // The flush beat (beat_q == LINE_LEN) and idle states drive zero.
  assign beat_live = (state_q == StStream) && (beat_q < LineLenC);
  assign col_word  = mem_q[beat_q[ColIdxW-1:0]];

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lane
    assign bus.out_battery[g] = (beat_live && (LanesW'(g) < lanes_q)) ? col_word[g] : '0;
  end

  assign lanes_loaded = lanes_q;
  assign err          = err_q;

endmodule
